// File: rtl/multi_mixer.sv
// multi_mixer: multi-channel drink mixer with current-limited pump scheduling, timed stir and abort.
// Optional MULTI_MIXER_PAUSE_EN adds a pause input that freezes pouring and stirring.
module multi_mixer #(
    parameter int unsigned NCH        = 6,
    parameter int unsigned QTY_W      = 4,
    parameter int unsigned TPU        = 12000000,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned MAX_ACTIVE = 2,
    parameter int unsigned STIR_TICKS = 200000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NCH*QTY_W-1:0] qty,
    input  logic                 abort,
`ifdef MULTI_MIXER_PAUSE_EN
    input  logic                 pause,
`endif
    output logic                 ready,
    output logic [NCH-1:0]       motor,
    output logic                 st,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted
);
    typedef enum logic [1:0] {IDLE, LOAD, POUR, STIR} state_t;
    state_t state, state_nx;
    logic [QTY_W-1:0] qty_l [NCH];
    logic [CNT_W-1:0] rem [NCH];
    logic [31:0] stir_cnt;
    logic [NCH-1:0] sel;
    logic any, hold;
`ifdef MULTI_MIXER_PAUSE_EN
    assign hold = pause && (state == POUR || state == STIR);
`else
    assign hold = 1'b0;
`endif
    assign ready = state == IDLE;
    assign busy = !ready;
    assign any = |sel;
    // lowest-index grant; running channels keep their slot because they stay lowest until empty
    always_comb begin
        int unsigned n;
        sel = '0;
        n = 0;
        for (int i = 0; i < NCH; i++)
            if (rem[i] != '0 && n < MAX_ACTIVE) begin
                sel[i] = 1'b1;
                n = n + 1;
            end
    end
    always_comb begin
        state_nx = state;
        if (state == IDLE)
            state_nx = (start && !abort) ? LOAD : IDLE;
        else if (abort)
            state_nx = IDLE;
        else if (!hold) begin
            if (state == LOAD)
                state_nx = POUR;
            else if (state == POUR && !any)
                state_nx = STIR;
            else if (state == STIR && stir_cnt == '0)
                state_nx = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            motor <= '0;
            st <= 1'b0;
            done <= 1'b0;
            aborted <= 1'b0;
            stir_cnt <= '0;
            for (int i = 0; i < NCH; i++) begin
                rem[i] <= '0;
                qty_l[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            aborted <= 1'b0;
            if (state != IDLE && abort) begin
                motor <= '0;
                st <= 1'b0;
                aborted <= 1'b1;
                stir_cnt <= '0;
                for (int i = 0; i < NCH; i++)
                    rem[i] <= '0;
            end else if (hold) begin
                motor <= '0;
                st <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        motor <= '0;
                        st <= 1'b0;
                        if (start && !abort)
                            for (int i = 0; i < NCH; i++)
                                qty_l[i] <= qty[i*QTY_W +: QTY_W];
                    end
                    LOAD:
                        for (int i = 0; i < NCH; i++)
                            rem[i] <= CNT_W'(qty_l[i]) * CNT_W'(TPU);
                    POUR: begin
                        motor <= sel;
                        for (int i = 0; i < NCH; i++)
                            if (sel[i])
                                rem[i] <= rem[i] - CNT_W'(1);
                        if (!any)
                            stir_cnt <= 32'(STIR_TICKS);
                    end
                    STIR:
                        if (stir_cnt != '0) begin
                            st <= 1'b1;
                            stir_cnt <= stir_cnt - 32'd1;
                        end else begin
                            st <= 1'b0;
                            done <= 1'b1;
                        end
                endcase
            end
        end
    end
endmodule
